// File: rtl/fb_scanout.sv
// -----------------------------------------------------------------------------
// fb_scanout
//
// Read-side client of the frame buffer. Generates VGA timing (640x480@60 with
// the default parameters) from Clk at a pixel rate of Clk/2. Issues one
// frame-buffer read address per pixel, maps the returned 5-bit colour index
// through a 32-entry palette, and drives 4:4:4 RGB plus syncs to the DAC.
//
// Optional feature macro: PALETTE_WR_EN
//   defined   - palette is a 32x12 register file written through Pal_* ports
//   undefined - Pal_* ports are absent and the palette is a fixed gray ROM
//
// Ports
//   Clk          in   system clock (50 MHz)
//   Reset_h      in   synchronous, active-high reset
//   Read_AddrX   out  frame-buffer read column (0 outside active video)
//   Read_AddrY   out  frame-buffer read row    (0 outside active video)
//   FbColorIdx   in   frame-buffer read data, valid 1 Clk after the address;
//                     only bits [4:0] are used
//   pixel_clk    out  pixel enable / DAC clock, high on every second Clk
//   hs, vs       out  active-low syncs, aligned with RGB
//   blank        out  1 = active video, 0 = blanking, aligned with RGB
//   Red/Green/Blue out 4-bit pixel colour
//   frame_start  out  one-Clk pulse on the edge the counters wrap to (0,0)
//   Pal_We       in   palette write strobe        (PALETTE_WR_EN only)
//   Pal_Addr     in   palette write index         (PALETTE_WR_EN only)
//   Pal_Data     in   palette write data {R,G,B}  (PALETTE_WR_EN only)
//
// Pipeline for pixel (h,v):
//   E0  counters become (h,v), Read_Addr registered
//   E1  frame buffer returns the index; sync/blank captured into stage 1
//   E2  palette output, hs, vs and blank all registered onto the pins
// -----------------------------------------------------------------------------
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC_S = 656,
  parameter int H_SYNC_E = 752,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC_S = 490,
  parameter int V_SYNC_E = 492,
  parameter int V_TOTAL  = 525
) (
  input  logic        Clk,
  input  logic        Reset_h,
  output logic [10:0] Read_AddrX,
  output logic [10:0] Read_AddrY,
  input  logic [7:0]  FbColorIdx,
  output logic        pixel_clk,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic        frame_start
`ifdef PALETTE_WR_EN
  ,
  input  logic        Pal_We,
  input  logic [4:0]  Pal_Addr,
  input  logic [11:0] Pal_Data
`endif
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] H_SS    = 11'(H_SYNC_S);
  localparam logic [10:0] H_SE    = 11'(H_SYNC_E);
  localparam logic [10:0] V_SS    = 11'(V_SYNC_S);
  localparam logic [10:0] V_SE    = 11'(V_SYNC_E);

  // Default palette entry: 4-bit gray level taken from the top index bits,
  // so entry 0 is black and entry 31 is white.
  function automatic logic [11:0] default_entry(input logic [4:0] idx);
    return {idx[4:1], idx[4:1], idx[4:1]};
  endfunction

  logic [10:0] hc;
  logic [10:0] vc;
  logic [10:0] hc_next;
  logic [10:0] vc_next;
  logic        active_next;
  logic        active_cur;
  logic        hs_cur;
  logic        vs_cur;
  logic        hs_d1;
  logic        vs_d1;
  logic        blank_d1;
  logic [11:0] pal_rd;

  // Upper index bits carry no colour information.
  logic unused_idx_bits;
  assign unused_idx_bits = ^FbColorIdx[7:5];

  // ---------------------------------------------------------------------------
  // Counter next-state. pixel_clk is the registered enable: counters only move
  // on the edges where it is currently high, i.e. every second Clk.
  // ---------------------------------------------------------------------------
  always_comb begin
    hc_next = hc;
    vc_next = vc;
    if (pixel_clk) begin
      if (hc == H_LAST) begin
        hc_next = '0;
        if (vc == V_LAST) begin
          vc_next = '0;
        end else begin
          vc_next = vc + 11'd1;
        end
      end else begin
        hc_next = hc + 11'd1;
      end
    end
  end

  assign active_next = (hc_next < H_ACT) && (vc_next < V_ACT);
  assign active_cur  = (hc < H_ACT) && (vc < V_ACT);
  assign hs_cur      = !((hc >= H_SS) && (hc < H_SE));
  assign vs_cur      = !((vc >= V_SS) && (vc < V_SE));

  // ---------------------------------------------------------------------------
  // Palette
  // ---------------------------------------------------------------------------
`ifdef PALETTE_WR_EN
  logic [11:0] pal [32];

  // A write and a lookup of the same entry in one cycle return the old value:
  // the lookup reads the register before the non-blocking update lands.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      for (int i = 0; i < 32; i++) begin
        pal[i] <= default_entry(5'(i));
      end
    end else if (Pal_We) begin
      pal[Pal_Addr] <= Pal_Data;
    end
  end

  assign pal_rd = pal[FbColorIdx[4:0]];
`else
  assign pal_rd = default_entry(FbColorIdx[4:0]);
`endif

  // ---------------------------------------------------------------------------
  // Timing, address and output pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      pixel_clk   <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      Read_AddrX  <= '0;
      Read_AddrY  <= '0;
      frame_start <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      blank_d1    <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      Red         <= '0;
      Green       <= '0;
      Blue        <= '0;
    end else begin
      pixel_clk <= ~pixel_clk;
      hc        <= hc_next;
      vc        <= vc_next;

      // Pulse only on an advancing edge that lands on (0,0); the reset state
      // itself is also (0,0) but never produces a pulse.
      frame_start <= pixel_clk && (hc_next == '0) && (vc_next == '0);

      // Address follows the counters on the edge they move; outside the
      // visible area it parks at (0,0) so it never leaves the frame buffer.
      if (pixel_clk) begin
        Read_AddrX <= active_next ? hc_next : 11'd0;
        Read_AddrY <= active_next ? vc_next : 11'd0;
      end

      // Stage 1: sync/blank of the pixel addressed on the previous edge.
      hs_d1    <= hs_cur;
      vs_d1    <= vs_cur;
      blank_d1 <= active_cur;

      // Stage 2: everything for that pixel hits the pins together.
      hs    <= hs_d1;
      vs    <= vs_d1;
      blank <= blank_d1;
      if (blank_d1) begin
        {Red, Green, Blue} <= pal_rd;
      end else begin
        {Red, Green, Blue} <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// -----------------------------------------------------------------------------
// Bench for fb_scanout. The main instance uses a shrunken raster (50x10 with a
// 40x6 visible area) so whole frames fit in a short run; a second instance
// with the default 640x480 timing is checked over one full line.
// Inputs are driven and outputs sampled on the falling edge of Clk.
// -----------------------------------------------------------------------------
module tb_fb_scanout;

  // Shrunken raster for the main instance.
  localparam int HA = 40, HSS = 42, HSE = 46, HT = 50;
  localparam int VA = 6,  VSS = 7,  VSE = 9,  VT = 10;

  int checks = 0;
  int errors = 0;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset_h = 1'b1;
  always #5 Clk = ~Clk;

  // main instance signals
  logic [10:0] Read_AddrX, Read_AddrY;
  logic [7:0]  FbColorIdx;
  logic        pixel_clk, hs, vs, blank, frame_start;
  logic [3:0]  Red, Green, Blue;
  logic        Pal_We = 1'b0;
  logic [4:0]  Pal_Addr = '0;
  logic [11:0] Pal_Data = '0;

  // default-timing instance signals
  logic [10:0] d_addr_x, d_addr_y;
  logic        d_pixel_clk, d_hs, d_vs, d_blank, d_frame_start;
  logic [3:0]  d_red, d_green, d_blue;

  // Frame-buffer model: mode 0 returns X%32 with one Clk latency (junk in
  // the upper bits), mode 1 a constant index 31, mode 2 a constant index 5.
  int         fb_mode = 0;
  logic [7:0] fb_q = '0;
  always @(posedge Clk) fb_q <= {3'b101, Read_AddrX[4:0]};
  assign FbColorIdx = (fb_mode == 1) ? 8'h3F : (fb_mode == 2) ? 8'hE5 : fb_q;

  fb_scanout #(
    .H_ACTIVE(HA), .H_SYNC_S(HSS), .H_SYNC_E(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_S(VSS), .V_SYNC_E(VSE), .V_TOTAL(VT)
  ) u_dut (
    .Clk(Clk), .Reset_h(Reset_h),
    .Read_AddrX(Read_AddrX), .Read_AddrY(Read_AddrY),
    .FbColorIdx(FbColorIdx),
    .pixel_clk(pixel_clk), .hs(hs), .vs(vs), .blank(blank),
    .Red(Red), .Green(Green), .Blue(Blue),
    .frame_start(frame_start)
`ifdef PALETTE_WR_EN
    , .Pal_We(Pal_We), .Pal_Addr(Pal_Addr), .Pal_Data(Pal_Data)
`endif
  );

  fb_scanout u_dut_def (
    .Clk(Clk), .Reset_h(Reset_h),
    .Read_AddrX(d_addr_x), .Read_AddrY(d_addr_y),
    .FbColorIdx(8'h1F),
    .pixel_clk(d_pixel_clk), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .Red(d_red), .Green(d_green), .Blue(d_blue),
    .frame_start(d_frame_start)
`ifdef PALETTE_WR_EN
    , .Pal_We(1'b0), .Pal_Addr(5'd0), .Pal_Data(12'h000)
`endif
  );

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Advance until the main instance shows address (x,y); ok=0 on timeout.
  task automatic wait_addr(input logic [10:0] x, input logic [10:0] y, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 3000) begin
      @(negedge Clk);
      n++;
      if (Read_AddrX == x && Read_AddrY == y) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_frame(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 3000) begin
      @(negedge Clk);
      n++;
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    int n;
    Reset_h = 1'b1;
    tick(3);
    checks++;
    if ({pixel_clk, hs, vs, blank, frame_start} !== 5'b01100) begin
      errors++;
      $display("FAIL reset_ctrl got pclk/hs/vs/blank/fs=%b expected 01100",
               {pixel_clk, hs, vs, blank, frame_start});
    end
    checks++;
    if ({Red, Green, Blue, Read_AddrX, Read_AddrY} !== 34'd0) begin
      errors++;
      $display("FAIL reset_data got rgb=%h x=%0d y=%0d expected 0", {Red, Green, Blue},
               Read_AddrX, Read_AddrY);
    end
    Reset_h = 1'b0;
    tick(1);
    checks++;
    if (pixel_clk !== 1'b1) begin
      errors++;
      $display("FAIL first_pixel_clk got %b expected 1", pixel_clk);
    end
    // Edge count from release to the first frame_start pulse: 50*10*2.
    n = 1;
    while (frame_start !== 1'b1 && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (n !== 1000) begin
      errors++;
      $display("FAIL frame_start_delay got %0d Clk expected 1000", n);
    end
  endtask

  // Counts over one whole frame (period 1000 Clk, so alignment is irrelevant).
  task automatic test_frame_counts;
    int hs_lo, vs_lo, blank_hi, fs_cnt;
    hs_lo = 0; vs_lo = 0; blank_hi = 0; fs_cnt = 0;
    repeat (1000) begin
      @(negedge Clk);
      if (hs === 1'b0) hs_lo++;
      if (vs === 1'b0) vs_lo++;
      if (blank === 1'b1) blank_hi++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    checks++;
    if (hs_lo !== 80) begin
      errors++;
      $display("FAIL hs_low_clks got %0d expected 80", hs_lo);
    end
    checks++;
    if (vs_lo !== 200) begin
      errors++;
      $display("FAIL vs_low_clks got %0d expected 200", vs_lo);
    end
    checks++;
    if (blank_hi !== 480) begin
      errors++;
      $display("FAIL active_clks got %0d expected 480", blank_hi);
    end
    checks++;
    if (fs_cnt !== 1) begin
      errors++;
      $display("FAIL frame_start_pulses got %0d expected 1", fs_cnt);
    end
  endtask

  task automatic test_pixel_pipeline;
    logic [10:0] xs  [3] = '{11'd2, 11'd17, 11'd31};
    logic [11:0] exp [3] = '{12'h111, 12'h888, 12'hFFF};
    bit ok;
    fb_mode = 0;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_frame_start got timeout expected pulse");
    end
    tick(1);
    checks++;
    if (blank !== 1'b0) begin
      errors++;
      $display("FAIL pixel0_early got blank=%b expected 0", blank);
    end
    tick(1);
    checks++;
    if ({blank, Red, Green, Blue} !== {1'b1, 12'h000}) begin
      errors++;
      $display("FAIL pixel0 got blank=%b rgb=%h expected 1 000", blank, {Red, Green, Blue});
    end
    for (int i = 0; i < 3; i++) begin
      wait_addr(xs[i], 11'd0, ok);
      tick(2);
      checks++;
      if (!ok || {blank, Red, Green, Blue} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL pixel_x%0d got ok=%0d blank=%b rgb=%h expected 1 %h", xs[i], ok,
                 blank, {Red, Green, Blue}, exp[i]);
      end
    end
  endtask

  task automatic test_blanking;
    int bad_blank, bad_active, zero_addr, out_of_range;
    bad_blank = 0; bad_active = 0; zero_addr = 0; out_of_range = 0;
    fb_mode = 1;
    tick(4);
    repeat (1000) begin
      @(negedge Clk);
      if (blank === 1'b0 && {Red, Green, Blue} !== 12'h000) bad_blank++;
      if (blank === 1'b1 && {Red, Green, Blue} !== 12'hFFF) bad_active++;
      if (Read_AddrX == 11'd0 && Read_AddrY == 11'd0) zero_addr++;
      if (Read_AddrX > 11'd39 || Read_AddrY > 11'd5) out_of_range++;
    end
    checks++;
    if (bad_blank !== 0) begin
      errors++;
      $display("FAIL blank_rgb_zero got %0d nonzero samples expected 0", bad_blank);
    end
    checks++;
    if (bad_active !== 0) begin
      errors++;
      $display("FAIL active_rgb_white got %0d wrong samples expected 0", bad_active);
    end
    // 260 invisible pixels plus pixel (0,0), two Clk each.
    checks++;
    if (zero_addr !== 522) begin
      errors++;
      $display("FAIL zero_addr_clks got %0d expected 522", zero_addr);
    end
    checks++;
    if (out_of_range !== 0) begin
      errors++;
      $display("FAIL addr_range got %0d samples beyond 39/5 expected 0", out_of_range);
    end
    fb_mode = 0;
  endtask

`ifdef PALETTE_WR_EN
  task automatic test_palette_write;
    bit ok;
    fb_mode = 2;
    wait_addr(11'd10, 11'd1, ok);
    Pal_We = 1'b1; Pal_Addr = 5'd5; Pal_Data = 12'hF00;
    tick(1);
    Pal_We = 1'b0;
    checks++;
    if (!ok || {Red, Green, Blue} !== 12'h222) begin
      errors++;
      $display("FAIL pal_same_cycle got ok=%0d rgb=%h expected 222", ok, {Red, Green, Blue});
    end
    tick(1);
    checks++;
    if ({Red, Green, Blue} !== 12'hF00) begin
      errors++;
      $display("FAIL pal_new_value got rgb=%h expected f00", {Red, Green, Blue});
    end
    Reset_h = 1'b1;
    tick(1);
    Reset_h = 1'b0;
    wait_addr(11'd10, 11'd0, ok);
    tick(2);
    checks++;
    if (!ok || {Red, Green, Blue} !== 12'h222) begin
      errors++;
      $display("FAIL pal_reset_default got ok=%0d rgb=%h expected 222", ok, {Red, Green, Blue});
    end
    fb_mode = 0;
  endtask
`endif

  task automatic test_mid_frame_reset;
    bit ok;
    fb_mode = 0;
    wait_addr(11'd30, 11'd3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_30_3 got timeout expected address");
    end
    Reset_h = 1'b1;
    tick(1);
    Reset_h = 1'b0;
    checks++;
    if ({pixel_clk, hs, vs, blank, frame_start, Red, Green, Blue, Read_AddrX, Read_AddrY}
        !== {5'b01100, 34'd0}) begin
      errors++;
      $display("FAIL midreset_outputs got pclk=%b hs=%b vs=%b blank=%b fs=%b rgb=%h x=%0d y=%0d expected reset values",
               pixel_clk, hs, vs, blank, frame_start, {Red, Green, Blue}, Read_AddrX, Read_AddrY);
    end
    tick(2);
    checks++;
    if ({blank, frame_start, Read_AddrX, Red, Green, Blue} !== {2'b10, 11'd1, 12'h000}) begin
      errors++;
      $display("FAIL midreset_restart got blank=%b fs=%b x=%0d rgb=%h expected 1 0 1 000",
               blank, frame_start, Read_AddrX, {Red, Green, Blue});
    end
    tick(4);
    checks++;
    if ({Red, Green, Blue} !== 12'h111) begin
      errors++;
      $display("FAIL midreset_pixel2 got rgb=%h expected 111", {Red, Green, Blue});
    end
  endtask

  // Full-size 640x480 timing over one visible line.
  task automatic test_default_line;
    int hs_lo, vs_lo, blank_hi, bad_rgb;
    logic [10:0] max_x;
    hs_lo = 0; vs_lo = 0; blank_hi = 0; bad_rgb = 0; max_x = '0;
    Reset_h = 1'b1;
    tick(3);
    Reset_h = 1'b0;
    repeat (1600) begin
      @(negedge Clk);
      if (d_hs === 1'b0) hs_lo++;
      if (d_vs === 1'b0) vs_lo++;
      if (d_blank === 1'b1) blank_hi++;
      if (d_blank === 1'b1 && {d_red, d_green, d_blue} !== 12'hFFF) bad_rgb++;
      if (d_addr_x > max_x) max_x = d_addr_x;
    end
    checks++;
    if (hs_lo !== 192) begin
      errors++;
      $display("FAIL def_hs_low got %0d Clk expected 192", hs_lo);
    end
    checks++;
    if (blank_hi !== 1280) begin
      errors++;
      $display("FAIL def_active got %0d Clk expected 1280", blank_hi);
    end
    checks++;
    if (vs_lo !== 0) begin
      errors++;
      $display("FAIL def_vs_low got %0d Clk expected 0", vs_lo);
    end
    checks++;
    if (max_x !== 11'd639) begin
      errors++;
      $display("FAIL def_max_x got %0d expected 639", max_x);
    end
    checks++;
    if (bad_rgb !== 0) begin
      errors++;
      $display("FAIL def_rgb got %0d wrong samples expected 0", bad_rgb);
    end
  endtask

  // ---------------------------------------------------------------------------
  // sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_frame_counts();
    test_pixel_pipeline();
    test_blanking();
`ifdef PALETTE_WR_EN
    test_palette_write();
`endif
    test_mid_frame_reset();
    test_default_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
